// File: rtl/antilog2_if.sv
// Handshake bundle for the antilog2 block: operand in (iValid/iReady), result out (oValid/oReady).
interface antilog2_if #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 10
);
  logic [M+N:0] number;
  logic         iValid;
  logic         iReady;
  logic [M+N:0] expNumber;
  logic         oValid;
  logic         oReady;

  modport master (
    output number, iValid, oReady,
    input  iReady, expNumber, oValid
  );

  modport slave (
    input  number, iValid, oReady,
    output iReady, expNumber, oValid
  );
endinterface

// File: rtl/antilog2.sv
// Sequential fixed-point base-2 antilog, expNumber = 2^number, signed 1.M.N in and out.
// Define ANTILOG2_ROUND_EN to round (half up) each partial product instead of truncating.
module antilog2 #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 10
) (
  input logic       clock,
  input logic       reset,
  antilog2_if.slave bus
);
  localparam int unsigned W  = M + N + 1;
  localparam int unsigned CW = N + 2;
  localparam int unsigned PW = 2 * N + 3;
  localparam int unsigned KW = $clog2(N + 2);

  localparam logic signed [W-1:0] I_MAX   = W'(M);
  localparam logic signed [W-1:0] I_MIN   = -$signed(W'(N + 1));
  localparam logic        [W-1:0] ACC_ONE = W'(1) << N;
  localparam logic        [W-1:0] ACC_SAT = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {INIT, WAIT, SPLIT, MUL_PREP, MUL, SCALE, SEND} state_t;

  // C_k = round(2^(2^-k) * 2^N), folded to constants at elaboration
  function automatic logic [CW-1:0] c_const(input int unsigned k);
    real v;
    v = (2.0 ** (1.0 / (2.0 ** k))) * (2.0 ** N);
    return CW'($rtoi(v + 0.5));
  endfunction

  logic [CW-1:0] c_tab [1:N];
  for (genvar g = 1; g <= N; g++) begin : g_const
    localparam logic [CW-1:0] C = c_const(g);
    assign c_tab[g] = C;
  end

  state_t               state_q, state_d;
  logic [W-1:0]         num_q, num_d;
  logic signed [W-1:0]  i_q, i_d;
  logic [N-1:0]         f_q, f_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        a_q, a_d;
  logic [PW-1:0]        b_q, b_d, p_q, p_d;
  logic                 iready_q, iready_d;
  logic                 ovalid_q, ovalid_d;
  logic [W-1:0]         exp_q, exp_d;

  logic signed [W-1:0]  i_split;
  logic [PW-1:0]        p_shr;
  logic                 in_xfer;

  assign i_split = $signed(num_q) >>> N;
  assign in_xfer = bus.iValid && iready_q;

`ifdef ANTILOG2_ROUND_EN
  assign p_shr = (p_q + (PW'(1) << (N - 1))) >> N;
`else
  assign p_shr = p_q >> N;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INIT;
      num_q    <= '0;
      i_q      <= '0;
      f_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      iready_q <= 1'b0;
      ovalid_q <= 1'b0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      i_q      <= i_d;
      f_q      <= f_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      iready_q <= iready_d;
      ovalid_q <= ovalid_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:     state_d = WAIT;
      WAIT:     if (in_xfer) state_d = SPLIT;
      SPLIT:    state_d = (i_split >= I_MAX || i_split < I_MIN) ? SEND : MUL_PREP;
      MUL_PREP: if (k_q > KW'(N)) state_d = SCALE;
                else if (f_q[N-1]) state_d = MUL;
      MUL:      if (a_q == '0) state_d = MUL_PREP;
      SCALE:    if (i_q == '0 || acc_q == '0) state_d = SEND;
      SEND:     if (bus.oReady) state_d = INIT;
      default:  state_d = INIT;
    endcase
  end

  // Fraction is consumed MSB-first from f_q, so f_q[N-1] is always bit f[N-k].
  always_comb begin
    num_d = num_q;
    i_d   = i_q;
    f_d   = f_q;
    acc_d = acc_q;
    k_d   = k_q;
    a_d   = a_q;
    b_d   = b_q;
    p_d   = p_q;
    unique case (state_q)
      INIT: begin
        acc_d = ACC_ONE;
        k_d   = KW'(1);
      end
      WAIT: if (in_xfer) num_d = bus.number;
      SPLIT: begin
        i_d = i_split;
        f_d = num_q[N-1:0];
        if (i_split >= I_MAX)     acc_d = ACC_SAT;
        else if (i_split < I_MIN) acc_d = '0;
      end
      MUL_PREP: if (k_q <= KW'(N)) begin
        if (!f_q[N-1]) begin
          k_d = k_q + KW'(1);
          f_d = f_q << 1;
        end else begin
          a_d = c_tab[k_q];
          b_d = PW'(acc_q);
          p_d = '0;
        end
      end
      MUL: if (a_q != '0) begin
        if (a_q[0]) p_d = p_q + b_q;
        a_d = a_q >> 1;
        b_d = b_q << 1;
      end else begin
        acc_d = W'(p_shr);
        k_d   = k_q + KW'(1);
        f_d   = f_q << 1;
      end
      SCALE: if (i_q != '0 && acc_q != '0) begin
        if (!i_q[W-1]) begin
          acc_d = acc_q << 1;
          i_d   = i_q - W'(1);
        end else begin
          acc_d = acc_q >> 1;
          i_d   = i_q + W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    iready_d = iready_q;
    ovalid_d = ovalid_q;
    exp_d    = exp_q;
    unique case (state_q)
      INIT: begin
        iready_d = 1'b1;
        ovalid_d = 1'b0;
      end
      WAIT:    if (in_xfer) iready_d = 1'b0;
      SEND:    if (bus.oReady) ovalid_d = 1'b0;
      default: ;
    endcase
    if (state_q != SEND && state_d == SEND) begin
      ovalid_d = 1'b1;
      exp_d    = {1'b0, acc_d[W-2:0]};
    end
  end

  assign bus.iReady    = iready_q;
  assign bus.oValid    = ovalid_q;
  assign bus.expNumber = exp_q;
endmodule

// File: tb/tb_antilog2.sv
// Scoreboard bench for antilog2 (M=4, N=10): directed operands, queued expected results.
module tb_antilog2;
  localparam int unsigned M       = 4;
  localparam int unsigned N       = 10;
  localparam int unsigned W       = M + N + 1;
  localparam int unsigned LAT_MAX = N * (N + 5) + M + N + 6;

  logic clock = 1'b0;
  logic reset = 1'b1;

  antilog2_if #(.M(M), .N(N)) bus ();
  antilog2 #(.M(M), .N(N)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_fifo[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endtask

  // Monitor: every accepted result is matched against the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && bus.oValid && bus.oReady) begin
      if (exp_fifo.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%04h, expected none", bus.expNumber);
      end else begin
        check("result", bus.expNumber, exp_fifo.pop_front());
      end
    end
  end

  task automatic do_op(input logic [W-1:0] num, input logic [W-1:0] want, input bit track);
    bit got;
    if (track) exp_fifo.push_back(want);
    bus.number = num;
    bus.iValid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (bus.iReady) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got iReady=0, expected 1 within 50 cycles");
    end
    @(posedge clock);
    #1;
    bus.iValid = 1'b0;
    bus.number = ~num;
    check("iready_drop", W'(bus.iReady), W'(0));
  endtask

  task automatic wait_out();
    int cnt;
    cnt = -1;
    for (int c = 1; c <= int'(LAT_MAX) + 5; c++) begin
      @(negedge clock);
      if (bus.oValid) begin
        cnt = c;
        break;
      end
    end
    n_vec++;
    if (cnt < 0 || cnt > int'(LAT_MAX)) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, expected <= %0d", cnt, LAT_MAX);
    end
  endtask

  task automatic run(input logic [W-1:0] num, input logic [W-1:0] want);
    do_op(num, want, 1'b1);
    wait_out();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    bus.number = '0;
    bus.iValid = 1'b0;
    bus.oReady = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_iready", W'(bus.iReady), W'(0));
    check("rst_ovalid", W'(bus.oValid), W'(0));
    check("rst_exp", bus.expNumber, W'(0));
    reset = 1'b0;

    run(15'h0000, 15'h0400);
    run(15'h0400, 15'h0800);
    run(15'h7C00, 15'h0200);
    run(15'h0200, 15'h05A8);
    run(15'h0C00, 15'h2000);
    run(15'h1000, 15'h3FFF);
    run(15'h4000, 15'h0000);
    run(15'h0300, 15'h06BA);
    run(15'h0E00, 15'h2D40);
    run(15'h7E00, 15'h02D4);
    run(15'h5800, 15'h0001);
    run(15'h5400, 15'h0000);

    // Backpressure: result must hold while oReady is low, then leave exactly once.
    bus.oReady = 1'b0;
    do_op(15'h0400, 15'h0800, 1'b1);
    wait_out();
    for (int c = 0; c < 7; c++) begin
      check("hold_ovalid", W'(bus.oValid), W'(1));
      check("hold_exp", bus.expNumber, 15'h0800);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    bus.oReady = 1'b1;
    @(posedge clock);
    #1;
    check("post_ovalid", W'(bus.oValid), W'(0));
    check("post_iready_1", W'(bus.iReady), W'(0));
    @(posedge clock);
    #1;
    check("post_iready_2", W'(bus.iReady), W'(1));

    // Reset during the multiply discards the operation.
    do_op(15'h0200, 15'h05A8, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_ovalid", W'(bus.oValid), W'(0));
    check("midrst_iready", W'(bus.iReady), W'(0));
    check("midrst_exp", bus.expNumber, W'(0));
    run(15'h0400, 15'h0800);

    repeat (3) @(posedge clock);
    check("queue_empty", W'(exp_fifo.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
